// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// stopwatch_ctrl: conditions the two stopwatch buttons and runs the start/pause/clear FSM
// that drives the Counter's init_regs/count_enabled, halting at STOP_VALUE.
module stopwatch_ctrl #(
  parameter int         CLK_FREQ        = 100000000,
  parameter int         DEBOUNCE_CYCLES = CLK_FREQ / 100,
  parameter int         CLEAR_CYCLES    = 2,
  parameter logic [7:0] STOP_VALUE      = 8'h99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [7:0] time_reading,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [1:0] state_leds
);

  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CLR_W     = $clog2(CLEAR_CYCLES + 1);
  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CLEARING = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       deb_dly_q, deb_prev_q;
  logic             warm_q;
  logic [1:0]       arm_q;
  logic [1:0]       press_q;

  state_t           state_q;
  logic [CLR_W-1:0] clr_cnt_q;
  logic             init_q, en_q;
  logic [1:0]       leds_q;

  assign btn_raw = {btn_clear, btn_start_stop};

  // Any sample that agrees with the debounced level restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // arm_q stays low until a button is seen released after reset, so a button held
  // through reset never produces a press; deb_dly_q aligns press timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '{default: '0};
      deb_dly_q  <= '0;
      deb_prev_q <= '0;
      warm_q     <= 1'b0;
      arm_q      <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      deb_dly_q  <= deb_q;
      deb_prev_q <= deb_dly_q;
      warm_q     <= 1'b1;
      arm_q      <= arm_q | ({2{warm_q}} & ~sync1_q);
      press_q    <= deb_dly_q & ~deb_prev_q & arm_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEARING;
      clr_cnt_q <= CLR_W'(CLEAR_CYCLES);
      init_q    <= 1'b1;
      en_q      <= 1'b0;
      leds_q    <= 2'b00;
    end else if (press_q[BTN_CLEAR]) begin
      state_q   <= ST_CLEARING;
      clr_cnt_q <= CLR_W'(CLEAR_CYCLES);
      init_q    <= 1'b1;
      en_q      <= 1'b0;
      leds_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_CLEARING: begin
          if (clr_cnt_q == CLR_W'(1)) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q - CLR_W'(1);
          end
        end
        ST_IDLE: begin
          if (press_q[BTN_START]) begin
            state_q <= ST_RUNNING;
            en_q    <= 1'b1;
            leds_q  <= 2'b01;
          end
        end
        ST_RUNNING: begin
          if (time_reading == STOP_VALUE) begin
            state_q <= ST_DONE;
            en_q    <= 1'b0;
            leds_q  <= 2'b11;
          end else if (press_q[BTN_START]) begin
            state_q <= ST_PAUSED;
            en_q    <= 1'b0;
            leds_q  <= 2'b10;
          end
        end
        ST_PAUSED: begin
          if (press_q[BTN_START]) begin
            state_q <= ST_RUNNING;
            en_q    <= 1'b1;
            leds_q  <= 2'b01;
          end
        end
        ST_DONE: begin
          en_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_CLEARING;
          clr_cnt_q <= CLR_W'(CLEAR_CYCLES);
          init_q    <= 1'b1;
          en_q      <= 1'b0;
          leds_q    <= 2'b00;
        end
      endcase
    end
  end

  assign init_regs     = init_q;
  assign count_enabled = en_q;
  assign state_leds    = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// tb_stopwatch_ctrl: directed stimulus with a sliding-window button model and an
// abstract FSM model compared against the DUT on every clock.
module tb_stopwatch_ctrl;

  localparam int         DEB   = 4;
  localparam int         CLR   = 2;
  localparam logic [7:0] STOP  = 8'h05;
  localparam int         MAXN  = 8192;

  localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [7:0] time_reading;
  logic       init_regs;
  logic       count_enabled;
  logic [1:0] state_leds;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(
    .CLK_FREQ       (400),
    .DEBOUNCE_CYCLES(DEB),
    .CLEAR_CYCLES   (CLR),
    .STOP_VALUE     (STOP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .time_reading  (time_reading),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .state_leds    (state_leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Histories indexed by clock edges since reset release (edge 1 = first edge with reset high).
  bit rawh  [2][MAXN];
  bit debh  [2][MAXN];
  bit armh  [2][MAXN];
  bit presh [2][MAXN];
  int n;
  int mst;
  int clr_exit;

  function automatic bit s_at(int b, int k);
    // Synchronised level seen after edge k: raw value from one edge earlier.
    return (k >= 2) ? rawh[b][k-1] : 1'b0;
  endfunction

  function automatic logic [3:0] model_out();
    case (mst)
      M_CLR:   return 4'b1_0_00;
      M_IDLE:  return 4'b0_0_00;
      M_RUN:   return 4'b0_1_01;
      M_PAUSE: return 4'b0_0_10;
      default: return 4'b0_0_11;
    endcase
  endfunction

  initial begin
    n = 0; mst = M_CLR; clr_exit = CLR;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        n = 0; mst = M_CLR; clr_exit = CLR;
        for (int b = 0; b < 2; b++) begin
          debh[b][0] = 1'b0; armh[b][0] = 1'b0; presh[b][0] = 1'b0;
        end
      end else if (n >= MAXN - 1) begin
        check("model_range", n, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "model history exhausted");
      end else begin
        n++;
        rawh[0][n] = btn_start_stop;
        rawh[1][n] = btn_clear;
        for (int b = 0; b < 2; b++) begin
          bit stable;
          // Level flips once the last DEB synchronised samples all disagree with it.
          stable = 1'b1;
          for (int j = n - DEB; j <= n - 1; j++)
            if (s_at(b, j) == debh[b][n-1]) stable = 1'b0;
          debh[b][n]  = stable ? ~debh[b][n-1] : debh[b][n-1];
          armh[b][n]  = armh[b][n-1] | (n >= 2 && rawh[b][n-1] == 1'b0);
          presh[b][n] = (n >= 3) && debh[b][n-2] && !debh[b][n-3] && armh[b][n-1];
        end
        if (presh[1][n-1]) begin
          mst = M_CLR; clr_exit = n + CLR;
        end else begin
          case (mst)
            M_CLR:   if (n == clr_exit) mst = M_IDLE;
            M_IDLE:  if (presh[0][n-1]) mst = M_RUN;
            M_RUN:   if (time_reading == STOP) mst = M_DONE;
                     else if (presh[0][n-1]) mst = M_PAUSE;
            M_PAUSE: if (presh[0][n-1]) mst = M_RUN;
            default: ;
          endcase
        end
      end
      #1;
      check("cycle_outputs", {init_regs, count_enabled, state_leds}, model_out());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk) btn_start_stop = 1'b1;
    idle(10);
    btn_start_stop = 1'b0;
    idle(10);
  endtask

  task automatic press_clear();
    @(negedge clk) btn_clear = 1'b1;
    idle(10);
    btn_clear = 1'b0;
    idle(10);
  endtask

  initial begin
    int rise, trans, hi;
    logic [1:0] last;
    reset_n = 1'b0; btn_start_stop = 1'b0; btn_clear = 1'b0; time_reading = 8'h00;

    // 1: reset and release
    @(negedge clk);
    check("rst_outputs", {init_regs, count_enabled, state_leds}, 4'b1000);
    idle(2);
    reset_n = 1'b1;
    @(negedge clk);
    check("clear_hold", init_regs, 1'b1);
    @(negedge clk);
    check("clear_done", {init_regs, count_enabled, state_leds}, 4'b0000);
    idle(2);

    // 2: clean start; enable appears 8 edges after the sampling edge (9th negedge)
    @(negedge clk) btn_start_stop = 1'b1;
    rise = 0; trans = 0; last = state_leds;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (count_enabled && rise == 0) rise = i;
      if (state_leds != last) trans++;
      last = state_leds;
    end
    check("start_latency", rise, 9);
    check("start_leds", state_leds, 2'b01);
    check("start_single", trans, 1);
    btn_start_stop = 1'b0;
    idle(10);

    // 3: bounce rejection then a settled press pauses
    for (int k = 0; k < 6; k++) begin
      btn_start_stop = (k % 2 == 0);
      idle(2);
    end
    check("bounce_hold", state_leds, 2'b01);
    btn_start_stop = 1'b1;
    trans = 0; last = state_leds;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_leds != last) trans++;
      last = state_leds;
    end
    check("bounce_single", trans, 1);
    check("paused", {count_enabled, state_leds}, 3'b0_10);
    btn_start_stop = 1'b0;
    idle(10);

    // 4: auto-stop at STOP_VALUE, then start ignored
    press_start();
    check("resume", state_leds, 2'b01);
    time_reading = 8'h04;
    idle(3);
    check("below_stop", state_leds, 2'b01);
    time_reading = 8'h05;
    @(negedge clk);
    check("auto_stop", {count_enabled, state_leds}, 3'b0_11);
    press_start();
    check("done_ignores_start", state_leds, 2'b11);
    time_reading = 8'h00;

    // 5: simultaneous clear and start while running
    press_clear();
    check("clear_to_idle", {init_regs, count_enabled, state_leds}, 4'b0000);
    press_start();
    check("run_again", state_leds, 2'b01);
    @(negedge clk);
    btn_start_stop = 1'b1; btn_clear = 1'b1;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (init_regs) hi++;
    end
    check("clear_window", hi, 2);
    check("clear_priority", {init_regs, count_enabled, state_leds}, 4'b0000);
    btn_start_stop = 1'b0; btn_clear = 1'b0;
    idle(10);

    // 6: reset while paused with start held
    press_start();
    press_start();
    check("paused_again", state_leds, 2'b10);
    @(negedge clk) btn_start_stop = 1'b1;
    idle(2);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {init_regs, count_enabled, state_leds}, 4'b1000);
    reset_n = 1'b1;
    idle(20);
    check("held_no_start", {init_regs, count_enabled, state_leds}, 4'b0000);
    btn_start_stop = 1'b0;
    idle(10);
    press_start();
    check("repress_start", state_leds, 2'b01);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
